// File: rtl/manchester_pkg.sv
// Shared symbol constants and framer state type for the Manchester line path.
// Defining MANCHESTER_FRAMER_IFG_EN adds the GAP state used for inter-frame spacing.
package manchester_pkg;

  localparam logic [7:0] PREAMBLE_SYM = 8'h55;
  localparam logic [7:0] SFD_SYM      = 8'hD5;
  localparam logic [7:0] ESC_SYM      = 8'hE5;
  localparam logic [7:0] REPLACE_SYM  = 8'hF5;

`ifdef MANCHESTER_FRAMER_IFG_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD,
    ST_GAP
  } framer_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD
  } framer_state_t;
`endif

endpackage

// File: rtl/manchester_framer.sv
// Wraps an escaped payload stream with preamble and SFD for the Manchester line encoder.
// Optional macro MANCHESTER_FRAMER_IFG_EN enforces IFG_CYCLES idle cycles after each frame.
module manchester_framer
  import manchester_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 8,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE_SYMBOL = PREAMBLE_SYM,
  parameter int                    PREAMBLE_LEN    = 7,
  parameter logic [DATA_WIDTH-1:0] SFD_SYMBOL      = SFD_SYM,
  parameter int                    IFG_CYCLES      = 12
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);

  // The escape stage emits ESC/REPLACE as payload, so the SFD must never alias them.
  if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 255) begin : g_bad_plen
    $error("PREAMBLE_LEN out of range 1..255");
  end
  if (IFG_CYCLES < 1 || IFG_CYCLES > 255) begin : g_bad_ifg
    $error("IFG_CYCLES out of range 1..255");
  end
  if (SFD_SYMBOL == DATA_WIDTH'(ESC_SYM) || SFD_SYMBOL == DATA_WIDTH'(REPLACE_SYM)) begin : g_bad_sfd
    $error("SFD_SYMBOL collides with an escape-stage symbol");
  end

  framer_state_t         r_state;
  logic [PRE_W-1:0]      r_pre_cnt;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;

  logic w_out_free;
  logic w_out_fire;
  logic w_in_fire;

  assign w_out_free    = !r_tvalid || m_axis_tready;
  assign w_out_fire    = r_tvalid && m_axis_tready;
  assign s_axis_tready = (r_state == ST_PAYLOAD) && w_out_free;
  assign w_in_fire     = s_axis_tvalid && s_axis_tready;

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;

`ifdef MANCHESTER_FRAMER_IFG_EN
  localparam int GAP_W = $clog2(IFG_CYCLES + 1);
  logic [GAP_W-1:0] r_gap_cnt;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= ST_IDLE;
      r_pre_cnt <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
`ifdef MANCHESTER_FRAMER_IFG_EN
      r_gap_cnt <= '0;
`endif
    end else begin
      case (r_state)
        // IDLE may still hold the previous frame's tlast beat when no gap is configured.
        ST_IDLE: begin
          if (w_out_free) begin
            if (s_axis_tvalid) begin
              r_state   <= ST_PREAMBLE;
              r_pre_cnt <= PRE_W'(PREAMBLE_LEN);
              r_tdata   <= PREAMBLE_SYMBOL;
              r_tlast   <= 1'b0;
              r_tvalid  <= 1'b1;
            end else begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
            end
          end
        end

        ST_PREAMBLE: begin
          if (w_out_fire) begin
            if (r_pre_cnt == PRE_W'(1)) begin
              r_state   <= ST_SFD;
              r_pre_cnt <= '0;
              r_tdata   <= SFD_SYMBOL;
            end else begin
              r_pre_cnt <= r_pre_cnt - PRE_W'(1);
            end
          end
        end

        ST_SFD: begin
          if (w_out_fire) begin
            r_state  <= ST_PAYLOAD;
            r_tvalid <= 1'b0;
          end
        end

        ST_PAYLOAD: begin
          if (w_in_fire) begin
            r_tdata  <= s_axis_tdata;
            r_tlast  <= s_axis_tlast;
            r_tvalid <= 1'b1;
            if (s_axis_tlast) begin
`ifdef MANCHESTER_FRAMER_IFG_EN
              r_state <= ST_GAP;
`else
              r_state <= ST_IDLE;
`endif
            end
          end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
          end
        end

`ifdef MANCHESTER_FRAMER_IFG_EN
        // The final gap cycle doubles as the IDLE decision so the gap is exactly IFG_CYCLES.
        ST_GAP: begin
          if (r_tvalid) begin
            if (m_axis_tready) begin
              r_tvalid  <= 1'b0;
              r_tlast   <= 1'b0;
              r_gap_cnt <= GAP_W'(IFG_CYCLES);
            end
          end else if (r_gap_cnt <= GAP_W'(1)) begin
            r_gap_cnt <= '0;
            if (s_axis_tvalid) begin
              r_state   <= ST_PREAMBLE;
              r_pre_cnt <= PRE_W'(PREAMBLE_LEN);
              r_tdata   <= PREAMBLE_SYMBOL;
              r_tlast   <= 1'b0;
              r_tvalid  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
`endif

        default: begin
          r_state  <= ST_IDLE;
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_framer.sv
// Scoreboard bench for manchester_framer: expected beats are queued as stimulus is driven
// and popped as the DUT transfers output beats.
`timescale 1ns/1ps
module tb_manchester_framer;

  localparam int DW      = 8;
  localparam int PLEN    = 7;
  localparam int IFG     = 12;
  localparam int TIMEOUT = 300;
`ifdef MANCHESTER_FRAMER_IFG_EN
  localparam int EXP_GAP = IFG;
`else
  localparam int EXP_GAP = 0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;

  always #5 aclk = ~aclk;

  manchester_framer #(
    .DATA_WIDTH     (DW),
    .PREAMBLE_SYMBOL(8'h55),
    .PREAMBLE_LEN   (PLEN),
    .SFD_SYMBOL     (8'hD5),
    .IFG_CYCLES     (IFG)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
  );

  int         compared = 0;
  int         mismatched = 0;
  logic [8:0] expQ[$];
  int         xferCount = 0;
  logic       toggleReady = 1'b0;
  logic       holdPending = 1'b0;
  logic [8:0] holdVal = '0;
  logic       gapCounting = 1'b0;
  int         gapCnt = 0;
  int         lastGap = -1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (toggleReady) m_axis_tready = ~m_axis_tready;
      else             m_axis_tready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each transfer, checks stall stability and measures inter-frame gaps.
  always @(negedge aclk) begin
    if (!aresetn) begin
      holdPending = 1'b0;
      gapCounting = 1'b0;
    end else begin
      if (holdPending && m_axis_tvalid)
        checkOutput("holdStable", {m_axis_tlast, m_axis_tdata}, holdVal);
      holdPending = m_axis_tvalid && !m_axis_tready;
      holdVal     = {m_axis_tlast, m_axis_tdata};
      if (gapCounting) begin
        if (m_axis_tvalid) begin
          lastGap     = gapCnt;
          gapCounting = 1'b0;
        end else begin
          gapCnt++;
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        xferCount++;
        if (expQ.size() == 0) checkOutput("extraBeat", {m_axis_tlast, m_axis_tdata}, 32'hFFFF_FFFF);
        else                  checkOutput("beat", {m_axis_tlast, m_axis_tdata}, expQ.pop_front());
        if (m_axis_tlast) begin
          gapCounting = 1'b1;
          gapCnt      = 0;
        end
      end
    end
  end

  task automatic pushFrameHeader();
    repeat (PLEN) expQ.push_back({1'b0, 8'h55});
    expQ.push_back({1'b0, 8'hD5});
  endtask

  task automatic sendBeat(input logic [7:0] d, input logic last);
    int waitCycles = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axis_tready && waitCycles < TIMEOUT) begin
      @(negedge aclk);
      waitCycles++;
    end
    if (waitCycles >= TIMEOUT) checkOutput("acceptTimeout", waitCycles, 0);
    expQ.push_back({last, d});
    @(posedge aclk);
    #1;
  endtask

  // Call at posedge+1. bubbleAfter < 0 disables the mid-payload bubble.
  task automatic applyStimulus(input logic [7:0] data[$], input int bubbleAfter,
                               input logic checkLatency, input logic keepValid);
    int lows;
    pushFrameHeader();
    if (checkLatency) begin
      s_axis_tdata  = data[0];
      s_axis_tlast  = (data.size() == 1);
      s_axis_tvalid = 1'b1;
      @(negedge aclk);
      checkOutput("latencyPre", m_axis_tvalid, 1'b0);
      @(negedge aclk);
      checkOutput("latencyFirst", {m_axis_tvalid, m_axis_tdata}, {1'b1, 8'h55});
    end
    for (int i = 0; i < data.size(); i++) begin
      sendBeat(data[i], i == data.size() - 1);
      if (i == bubbleAfter) begin
        s_axis_tvalid = 1'b0;
        lows = 0;
        repeat (5) begin
          @(negedge aclk);
          if (!m_axis_tvalid) lows++;
        end
        @(posedge aclk);
        #1;
        checkOutput("bubbleLows", lows, 4);
      end
    end
    if (!keepValid) s_axis_tvalid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < TIMEOUT) begin
      @(posedge aclk);
      n++;
    end
    repeat (IFG + 3) @(posedge aclk);
    #1;
    checkOutput("queueDrained", expQ.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] frm[$];
    int n;

    #2;
    checkOutput("rstValid", m_axis_tvalid, 1'b0);
    checkOutput("rstData",  m_axis_tdata, 8'h00);
    checkOutput("rstLast",  m_axis_tlast, 1'b0);
    checkOutput("rstSReady", s_axis_tready, 1'b0);
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    $display("[TB] basic frame with tready held high");
    frm = '{8'h01, 8'h02, 8'h03};
    applyStimulus(frm, -1, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] same frame with tready toggling");
    toggleReady = 1'b1;
    applyStimulus(frm, -1, 1'b0, 1'b0);
    waitDrain();
    toggleReady = 1'b0;
    @(posedge aclk);
    #1;

    $display("[TB] escaped payload passes through");
    frm = '{8'hE5, 8'hF5};
    applyStimulus(frm, -1, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] payload with a 5-cycle input bubble");
    frm = '{8'h10, 8'h20, 8'h30, 8'h40};
    applyStimulus(frm, 1, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] back-to-back frames, expected gap %0d", EXP_GAP);
    lastGap = -1;
    frm = '{8'hA1, 8'hA2};
    applyStimulus(frm, -1, 1'b0, 1'b1);
    frm = '{8'hB1, 8'hB2, 8'hB3};
    applyStimulus(frm, -1, 1'b0, 1'b0);
    checkOutput("interFrameGap", lastGap, EXP_GAP);
    waitDrain();

    $display("[TB] reset during 4th preamble beat");
    n = xferCount;
    pushFrameHeader();
    s_axis_tdata  = 8'h77;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < TIMEOUT && xferCount != n + 3; c++) begin
      @(posedge aclk);
      #2;
    end
    checkOutput("fourthBeat", {m_axis_tvalid, m_axis_tdata}, {1'b1, 8'h55});
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    expQ.delete();
    #1;
    checkOutput("midRstValid", m_axis_tvalid, 1'b0);
    checkOutput("midRstData",  m_axis_tdata, 8'h00);
    checkOutput("midRstLast",  m_axis_tlast, 1'b0);
    checkOutput("midRstSReady", s_axis_tready, 1'b0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    frm = '{8'h5A, 8'hC3};
    applyStimulus(frm, -1, 1'b1, 1'b0);
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
